tft_8080_writer: RTL and testbench

- Parametrised write-only controller for 8080-style parallel TFT panels (ILI9341 class).
- Drives tftWR/tftRD/tftRS/tftRESET/tftData from a queued command/data stream.
- Sits between the video/CPU-side producer and the TFT pins at top level.
- Next generation of the fixed 16-bit TFT output: configurable bus width, programmable strobe timing, FIFO buffering, hardware reset sequencing.

---
 rtl/tft_8080_writer.sv | 235 +++++++++++++++++++++++
 tb/tb_tft_8080_writer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_8080_writer.sv
// Write-only 8080 parallel TFT controller: FIFO, strobe timing, panel reset.
// Optional macro TFT_FILL_EN adds a per-entry repeat count (in_count).
module tft_8080_writer #(
  parameter int DATA_W       = 16,
  parameter int FIFO_AW      = 4,
  parameter int WR_LOW_CYC   = 2,
  parameter int WR_HIGH_CYC  = 2,
  parameter int RST_LOW_CYC  = 280,
  parameter int RST_WAIT_CYC = 3360
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_rs,
  input  logic [DATA_W-1:0] in_data,
`ifdef TFT_FILL_EN
  input  logic [15:0]       in_count,
`endif
  input  logic              hw_reset_req,
  output logic              busy,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              tftWR,
  output logic              tftRD,
  output logic              tftRS,
  output logic              tftRESET,
  output logic [DATA_W-1:0] tftData
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [15:0] RST_LO_LAST = 16'(RST_LOW_CYC - 1);
  localparam logic [15:0] RST_WT_LAST = 16'(RST_WAIT_CYC - 1);
  localparam logic [15:0] WR_LO_LAST  = 16'(WR_LOW_CYC - 1);
  localparam logic [15:0] WR_HI_LAST  = 16'(WR_HIGH_CYC - 1);

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_IDLE,
    S_WR_LO,
    S_WR_HI
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         timer_q, timer_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    level_q, level_d;
  logic                fifo_ne_q, fifo_ne_d;
  logic                wr_q, wr_d;
  logic                rs_q, rs_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                tft_rst_q, tft_rst_d;
  logic [DATA_W:0]     mem_q [DEPTH];
`ifdef TFT_FILL_EN
  logic [15:0]         cnt_mem_q [DEPTH];
  logic [15:0]         rep_q, rep_d;
`endif

  logic               push;
  logic               pop;
  logic [FIFO_AW-1:0] rd_nxt;
  logic [DATA_W:0]    head;

  assign in_ready = (level_q != FULL_LVL);
  assign push     = in_valid && in_ready && !hw_reset_req;
  assign rd_nxt   = rd_ptr_q + FIFO_AW'(1);
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_rs, in_data};
`ifdef TFT_FILL_EN
      cnt_mem_q[wr_ptr_q] <= in_count;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    wr_d      = wr_q;
    rs_d      = rs_q;
    data_d    = data_q;
    tft_rst_d = tft_rst_q;
    pop       = 1'b0;
`ifdef TFT_FILL_EN
    rep_d     = rep_q;
`endif
    unique case (state_q)
      S_RST_LOW: begin
        if (timer_q == RST_LO_LAST) begin
          timer_d   = '0;
          tft_rst_d = 1'b1;
          state_d   = S_RST_WAIT;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_RST_WAIT: begin
        if (timer_q == RST_WT_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_IDLE: begin
        // fifo_ne_q adds the cycle between a push and the strobe
        if (fifo_ne_q && level_q != '0) begin
          rs_d    = head[DATA_W];
          data_d  = head[DATA_W-1:0];
          wr_d    = 1'b0;
          timer_d = '0;
          state_d = S_WR_LO;
`ifdef TFT_FILL_EN
          rep_d   = cnt_mem_q[rd_ptr_q];
`else
          pop     = 1'b1;
`endif
        end
      end
      S_WR_LO: begin
        if (timer_q == WR_LO_LAST) begin
          wr_d    = 1'b1;
          timer_d = '0;
          state_d = S_WR_HI;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_WR_HI: begin
        if (timer_q == WR_HI_LAST) begin
          timer_d = '0;
`ifdef TFT_FILL_EN
          if (rep_q != '0) begin
            rep_d   = rep_q - 16'd1;
            wr_d    = 1'b0;
            state_d = S_WR_LO;
          end else begin
            // head entry is retired only after its last repetition
            pop = 1'b1;
            if (level_q > LVL_ONE) begin
              rs_d    = mem_q[rd_nxt][DATA_W];
              data_d  = mem_q[rd_nxt][DATA_W-1:0];
              rep_d   = cnt_mem_q[rd_nxt];
              wr_d    = 1'b0;
              state_d = S_WR_LO;
            end else begin
              state_d = S_IDLE;
            end
          end
`else
          if (level_q != '0) begin
            pop     = 1'b1;
            rs_d    = head[DATA_W];
            data_d  = head[DATA_W-1:0];
            wr_d    = 1'b0;
            state_d = S_WR_LO;
          end else begin
            state_d = S_IDLE;
          end
`endif
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = S_RST_LOW;
    endcase
    if (hw_reset_req) begin
      state_d   = S_RST_LOW;
      timer_d   = '0;
      wr_d      = 1'b1;
      tft_rst_d = 1'b0;
      pop       = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d  = rd_ptr_q + FIFO_AW'(pop);
    level_d   = level_q + {{FIFO_AW{1'b0}}, push}
                        - {{FIFO_AW{1'b0}}, pop};
    fifo_ne_d = (level_q != '0) && !pop;
    if (hw_reset_req) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      fifo_ne_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_RST_LOW;
      timer_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      fifo_ne_q <= 1'b0;
      wr_q      <= 1'b1;
      rs_q      <= 1'b1;
      data_q    <= '0;
      tft_rst_q <= 1'b0;
`ifdef TFT_FILL_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      fifo_ne_q <= fifo_ne_d;
      wr_q      <= wr_d;
      rs_q      <= rs_d;
      data_q    <= data_d;
      tft_rst_q <= tft_rst_d;
`ifdef TFT_FILL_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign busy       = !(state_q == S_IDLE && level_q == '0);
  assign fifo_level = level_q;
  assign tftWR      = wr_q;
  assign tftRD      = 1'b1;
  assign tftRS      = rs_q;
  assign tftRESET   = tft_rst_q;
  assign tftData    = data_q;

endmodule

// File: tb/tb_tft_8080_writer.sv
// Bench for tft_8080_writer: directed timing steps plus random word streams
// compared against an ordered list of expected panel writes.
module tb_tft_8080_writer;
  localparam int DW = 16, AW = 4, WLO = 2, WHI = 2;
  localparam int RLO = 280, RWT = 3360, DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_rs = 1'b0, hw_reset_req = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, busy, tftWR, tftRD, tftRS, tftRESET;
  logic [AW:0] fifo_level;
  logic [DW-1:0] tftData;

  logic u8_valid = 1'b0, u8_rs = 1'b0;
  logic [7:0] u8_data = '0;
  logic u8_ready, u8_busy, u8_wr, u8_rd, u8_rsp, u8_rst;
  logic [2:0] u8_level;
  logic [7:0] u8_bus;
`ifdef TFT_FILL_EN
  logic [15:0] in_count = '0;
  logic [15:0] u8_count = '0;
`endif

  int errors = 0, checks = 0, cyc = 0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  int stab_bad = 0, len_bad = 0;

  always #5 clk = ~clk;

  tft_8080_writer #(
    .DATA_W(DW), .FIFO_AW(AW), .WR_LOW_CYC(WLO), .WR_HIGH_CYC(WHI),
    .RST_LOW_CYC(RLO), .RST_WAIT_CYC(RWT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_data(in_data),
`ifdef TFT_FILL_EN
    .in_count(in_count),
`endif
    .hw_reset_req(hw_reset_req), .busy(busy), .fifo_level(fifo_level),
    .tftWR(tftWR), .tftRD(tftRD), .tftRS(tftRS), .tftRESET(tftRESET),
    .tftData(tftData)
  );

  tft_8080_writer #(
    .DATA_W(8), .FIFO_AW(2), .WR_LOW_CYC(2), .WR_HIGH_CYC(2),
    .RST_LOW_CYC(4), .RST_WAIT_CYC(4)
  ) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(u8_valid), .in_ready(u8_ready),
    .in_rs(u8_rs), .in_data(u8_data),
`ifdef TFT_FILL_EN
    .in_count(u8_count),
`endif
    .hw_reset_req(1'b0), .busy(u8_busy), .fifo_level(u8_level),
    .tftWR(u8_wr), .tftRD(u8_rd), .tftRS(u8_rsp), .tftRESET(u8_rst),
    .tftData(u8_bus)
  );

  // pin monitor: record each write at its falling strobe
  logic prev_wr = 1'b1;
  logic [16:0] cur = '0;
  int low_cnt = 0;
  always @(negedge clk) begin
    if (prev_wr && !tftWR) begin
      got_q.push_back({tftRS, tftData});
      cur = {tftRS, tftData};
      low_cnt = 1;
    end else if (!tftWR) begin
      low_cnt++;
      if ({tftRS, tftData} !== cur) stab_bad++;
    end else if (!prev_wr && tftWR) begin
      if (low_cnt != WLO) len_bad++;
      if ({tftRS, tftData} !== cur) stab_bad++;
    end
    prev_wr = tftWR;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input logic rs, input logic [15:0] d);
    in_valid = 1'b1;
    in_rs = rs;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic cmp_got(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size()) chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic hw_reset();
    hw_reset_req = 1'b1;
    tick();
    hw_reset_req = 1'b0;
  endtask

  initial begin
    int base, p;
    logic [16:0] w;
    logic [16:0] words[8];

    // power-up
    repeat (3) @(posedge clk);
    #1;
    cyc = 0;
    chk("rst_wr", 32'(tftWR), 32'd1);
    chk("rst_rd", 32'(tftRD), 32'd1);
    chk("rst_rs", 32'(tftRS), 32'd1);
    chk("rst_data", 32'(tftData), 32'd0);
    chk("rst_reset", 32'(tftRESET), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;

    // 8-bit instance is out of reset sequencing after 8 clocks
    run_to(10);
    u8_valid = 1'b1;
    u8_rs = 1'b1;
    u8_data = 8'hA5;
    tick();
    u8_valid = 1'b0;
    tick();
    chk("u8_wr_hi", 32'(u8_wr), 32'd1);
    tick();
    chk("u8_wr_lo", 32'(u8_wr), 32'd0);
    chk("u8_data", 32'(u8_bus), 32'hA5);
    chk("u8_rs", 32'(u8_rsp), 32'd1);
    chk("u8_rd", 32'(u8_rd), 32'd1);

    run_to(RLO - 1);
    chk("pu_reset_low", 32'(tftRESET), 32'd0);
    tick();
    chk("pu_reset_high", 32'(tftRESET), 32'd1);
    run_to(RLO + RWT - 1);
    chk("pu_busy", 32'(busy), 32'd1);
    tick();
    chk("pu_idle", 32'(busy), 32'd0);
    chk("pu_no_writes", got_q.size(), 32'd0);

    // two words back to back
    push(1'b0, 16'h002C);
    p = cyc;
    push(1'b1, 16'hF800);
    chk("b2b_wr_n1", 32'(tftWR), 32'd1);
    run_to(p + 2);
    chk("b2b_wr_n2", 32'(tftWR), 32'd0);
    chk("b2b_d0", 32'(tftData), 32'h002C);
    chk("b2b_rs0", 32'(tftRS), 32'd0);
    run_to(p + 3);
    chk("b2b_wr_n3", 32'(tftWR), 32'd0);
    run_to(p + 4);
    chk("b2b_wr_n4", 32'(tftWR), 32'd1);
    chk("b2b_hold", 32'(tftData), 32'h002C);
    run_to(p + 6);
    chk("b2b_wr_n6", 32'(tftWR), 32'd0);
    chk("b2b_d1", 32'(tftData), 32'hF800);
    chk("b2b_rs1", 32'(tftRS), 32'd1);
    run_to(p + 8);
    chk("b2b_wr_n8", 32'(tftWR), 32'd1);
    wait_idle("b2b_idle", 20);
    exp_q.push_back({1'b0, 16'h002C});
    exp_q.push_back({1'b1, 16'hF800});
    cmp_got("b2b_seq");

    // fill the FIFO while the panel is in its post-reset wait
    hw_reset();
    base = cyc;
    chk("fill_reset", 32'(tftRESET), 32'd0);
    run_to(base + RLO + 5);
    chk("fill_in_wait", 32'(tftRESET), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      w = 17'($urandom);
      exp_q.push_back(w);
      push(w[16], w[15:0]);
    end
    chk("full_level", 32'(fifo_level), 32'(DEPTH));
    chk("full_ready", 32'(in_ready), 32'd0);
    push(1'b1, 16'hDEAD);
    chk("full_ignored", 32'(fifo_level), 32'(DEPTH));
    chk("full_no_early", got_q.size(), 32'd0);
    wait_idle("full_idle", RLO + RWT + DEPTH * (WLO + WHI) + 50);
    cmp_got("full_seq");

    // abort during the third of eight queued writes
    for (int i = 0; i < 8; i++) begin
      words[i] = 17'($urandom);
      push(words[i][16], words[i][15:0]);
      if (i == 0) p = cyc;
    end
    run_to(p + 2 * (WLO + WHI) + 2);
    chk("abort_wr_lo", 32'(tftWR), 32'd0);
    chk("abort_d3", 32'(tftData), 32'(words[2][15:0]));
    hw_reset_req = 1'b1;
    in_valid = 1'b1;
    in_rs = 1'b0;
    in_data = 16'hBEEF;
    tick();
    hw_reset_req = 1'b0;
    in_valid = 1'b0;
    base = cyc;
    chk("abort_wr", 32'(tftWR), 32'd1);
    chk("abort_level", 32'(fifo_level), 32'd0);
    chk("abort_reset", 32'(tftRESET), 32'd0);
    for (int i = 0; i < 3; i++) exp_q.push_back(words[i]);
    cmp_got("abort_seq");
    run_to(base + RLO - 1);
    chk("abort_reset_low", 32'(tftRESET), 32'd0);
    tick();
    chk("abort_reset_high", 32'(tftRESET), 32'd1);
    len_bad = 0;
    wait_idle("abort_idle", RWT + 20);
    chk("abort_no_more", got_q.size(), 32'd0);

    // random stream with random gaps
    for (int i = 0; i < 12; i++) begin
      w = 17'($urandom);
      chk("rnd_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(w);
      push(w[16], w[15:0]);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle("rnd_idle", 12 * (WLO + WHI) + 40);
    cmp_got("rnd_seq");

`ifdef TFT_FILL_EN
    in_count = 16'd4;
    push(1'b1, 16'h07E0);
    p = cyc;
    in_count = '0;
    run_to(p + 4 * (WLO + WHI) + 2);
    chk("fill_5th_lo", 32'(tftWR), 32'd0);
    chk("fill_lvl_mid", 32'(fifo_level), 32'd1);
    run_to(p + 5 * (WLO + WHI) + 3);
    chk("fill_lvl_end", 32'(fifo_level), 32'd0);
    repeat (5) exp_q.push_back({1'b1, 16'h07E0});
    wait_idle("fill_idle", 40);
    cmp_got("fill_seq");
`endif

    chk("strobe_stable", stab_bad, 32'd0);
    chk("strobe_len", len_bad, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
